// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter for the shared regfile write port, with a pending-write scoreboard
//
// Build option: define WB_RR_ARB_EN for round-robin arbitration.
// Without it, fixed priority is used and the lowest index wins.

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [5*NUM_REQ-1:0]      req_addr_i,
  input  logic [XLEN*NUM_REQ-1:0]   req_data_i,
  output logic                      rf_we_o,
  output logic [4:0]                rf_waddr_o,
  output logic [XLEN-1:0]           rf_wdata_o,
  input  logic                      sb_set_i,
  input  logic [4:0]                sb_set_addr_i,
  input  logic                      flush_i,
  input  logic [4:0]                rs1_addr_i,
  input  logic [4:0]                rs2_addr_i,
  input  logic [4:0]                rd_addr_i,
  output logic                      hazard_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [4:0]         win_addr;
  logic [XLEN-1:0]    win_data;
  logic               handshake;
  logic [31:0]        pend_q;
  logic [31:0]        pend_d;

`ifdef WB_RR_ARB_EN
  logic [IDX_W-1:0]   rr_ptr_q;

  // Round-robin pick: scan starting one past the last winner, first valid wins
  always_comb begin
    int k;
    k         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    win_addr  = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr_q) + 1 + i) % NUM_REQ;
      if (!grant_any && req_valid_i[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
        win_addr  = req_addr_i[5*k +: 5];
        win_data  = req_data_i[XLEN*k +: XLEN];
      end
    end
  end

  // Pointer remembers the last granted requester; idle cycles leave it alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (handshake) begin
      rr_ptr_q <= grant_idx;
    end
  end
`else
  // Fixed-priority pick: lowest-indexed valid requester wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    win_addr  = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid_i[i]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(i);
        win_addr  = req_addr_i[5*i +: 5];
        win_data  = req_data_i[XLEN*i +: XLEN];
      end
    end
  end
`endif

  // No grants while reset is held, so nothing is accepted and then dropped
  assign handshake = grant_any & ~rst_i;

  // One-hot ready to the chosen requester; depends only on valids and state
  always_comb begin
    req_ready_o = '0;
    if (handshake) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Register the accepted write; x0 is accepted but never produces an enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= handshake && (win_addr != 5'd0);
      if (handshake) begin
        rf_waddr_o <= win_addr;
        rf_wdata_o <= win_data;
      end
    end
  end

  // Scoreboard next state: flush, then commit clear, then issue set (set always survives)
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end
    if (rf_we_o) begin
      pend_d[rf_waddr_o] = 1'b0;
    end
    if (sb_set_i) begin
      pend_d[sb_set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard state; bit 0 is held at zero so x0 never reports a hazard
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign hazard_o = pend_q[rs1_addr_i] | pend_q[rs2_addr_i] | pend_q[rd_addr_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int N = 3;
  localparam int X = 32;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [5*N-1:0] req_addr;
  logic [X*N-1:0] req_data;
  logic           rf_we;
  logic [4:0]     rf_waddr;
  logic [X-1:0]   rf_wdata;
  logic           sb_set;
  logic [4:0]     sb_set_addr;
  logic           flush;
  logic [4:0]     rs1, rs2, rd;
  logic           hazard;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_pend [32];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [X-1:0] m_wdata;
  int          m_ptr = N - 1;
  int          last_w = -1;

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .sb_set_i      (sb_set),
    .sb_set_addr_i (sb_set_addr),
    .flush_i       (flush),
    .rs1_addr_i    (rs1),
    .rs2_addr_i    (rs2),
    .rd_addr_i     (rd),
    .hazard_o      (hazard)
  );

  always #5 clk_i = ~clk_i;

  function automatic int model_winner();
    int w;
    w = -1;
    if (rst_i) return -1;
`ifdef WB_RR_ARB_EN
    for (int i = 0; i < N; i++) begin
      if (w < 0 && req_valid[(m_ptr + 1 + i) % N]) w = (m_ptr + 1 + i) % N;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) w = i;
    end
`endif
    return w;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = model_winner();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_hazard();
    return m_pend[rs1] | m_pend[rs2] | m_pend[rd];
  endfunction

  task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [X-1:0] d);
    req_valid[k]       = v;
    req_addr[5*k +: 5] = a;
    req_data[X*k +: X] = d;
  endtask

  // advance one clock and update the model with the values seen at the edge
  task automatic tick();
    int w;
    bit nxt [32];
    w = model_winner();
    last_w = w;
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_ptr = N - 1;
    end else begin
      for (int i = 0; i < 32; i++) nxt[i] = flush ? 1'b0 : m_pend[i];
      if (m_we) nxt[m_waddr] = 1'b0;
      if (sb_set && sb_set_addr != 0) nxt[sb_set_addr] = 1'b1;
      m_pend = nxt;
      m_we = (w >= 0) && (req_addr[5*w +: 5] != 0);
      if (w >= 0) begin
        m_waddr = req_addr[5*w +: 5];
        m_wdata = req_data[X*w +: X];
        m_ptr   = w;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid = '1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'($urandom_range(1, 31)), $urandom());
    rs1 = 5'd3; rs2 = 5'd4; rd = 5'd5;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
      tick();
    end
    #2;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
      errors++; $display("FAIL reset_rf got we=%b a=%0d d=%h exp 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard); end
  endtask

  task automatic test_single_write();
    rst_i = 1'b0;
    req_valid = '0;
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #2;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", req_ready); end
    tick();
    req_valid = '0;
    #2;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write got we=%b a=%0d d=%h exp 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5) begin
      errors++; $display("FAIL single_idle got we=%b a=%0d exp 0/5", rf_we, rf_waddr);
    end
  endtask

  task automatic test_back_to_back();
    int seq [4];
`ifdef WB_RR_ARB_EN
    seq = '{0, 1, 2, 0};
`else
    seq = '{0, 0, 0, 0};
`endif
    rst_i = 1'b1; req_valid = '0;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'($urandom_range(1, 31)), $urandom());
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (req_ready !== (3'b001 << seq[c])) begin
        errors++; $display("FAIL contention_grant%0d got %b exp %b", c, req_ready, 3'b001 << seq[c]);
      end
      tick();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata || rf_we !== 1'b1) begin
        errors++; $display("FAIL contention_write%0d got %b/%0d/%h exp %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_scoreboard();
    rs1 = 5'd7; rs2 = 5'd0; rd = 5'd0;
    sb_set = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    #2;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("FAIL sb_set_hazard got %b exp 1", hazard); end
    set_req(0, 1'b1, 5'd7, $urandom());
    tick();
    req_valid = '0;
    #2;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || hazard !== 1'b1) begin
      errors++; $display("FAIL sb_commit_cycle got we=%b a=%0d hz=%b exp 1/7/1", rf_we, rf_waddr, hazard);
    end
    tick();
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b exp 0", hazard); end
    // set and commit of the same register in one cycle: set wins
    sb_set = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    set_req(0, 1'b1, 5'd7, $urandom());
    tick();
    req_valid = '0;
    sb_set = 1'b1; sb_set_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    #2;
    checks++;
    if (hazard !== 1'b1 || hazard !== exp_hazard()) begin
      errors++; $display("FAIL sb_set_beats_clear got %b exp 1", hazard);
    end
    set_req(0, 1'b1, 5'd7, $urandom());
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL sb_final_clear got %b exp 0", hazard); end
  endtask

  task automatic test_x0();
    req_valid = '0;
    set_req(0, 1'b1, 5'd0, 32'h1);
    #2;
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got %b exp 001", req_ready); end
    tick();
    req_valid = '0;
    #2;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", rf_we); end
    sb_set = 1'b1; sb_set_addr = 5'd0;
    tick();
    sb_set = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard got %b exp 0", hazard); end
  endtask

  task automatic test_flush();
    sb_set = 1'b1; sb_set_addr = 5'd3;
    tick();
    sb_set_addr = 5'd9;
    tick();
    flush = 1'b1; sb_set_addr = 5'd12;
    tick();
    flush = 1'b0; sb_set = 1'b0;
    rs2 = 5'd0; rd = 5'd0;
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      #1;
      checks++;
      if (hazard !== (r == 12) || hazard !== exp_hazard()) begin
        errors++; $display("FAIL flush_reg%0d got %b exp %b", r, hazard, r == 12);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    sb_set = 1'b1; sb_set_addr = 5'd20;
    tick();
    sb_set = 1'b0;
    req_valid = '0;
    set_req(1, 1'b1, 5'd8, $urandom());
    rst_i = 1'b1;
    #2;
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL rstmid_ready got %b exp 000", req_ready); end
    tick();
    rst_i = 1'b0;
    req_valid = '0;
    rs1 = 5'd20;
    #2;
    checks++;
    if (rf_we !== 1'b0 || hazard !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got we=%b hz=%b exp 0/0", rf_we, hazard);
    end
  endtask

  task automatic test_random();
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      rst_i = ($urandom_range(0, 63) == 0);
      sb_set = ($urandom_range(0, 3) == 0);
      sb_set_addr = 5'($urandom());
      flush = ($urandom_range(0, 15) == 0);
      rs1 = 5'($urandom()); rs2 = 5'($urandom()); rd = 5'($urandom());
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] || last_w == k)
          set_req(k, 1'($urandom()), 5'($urandom()), $urandom());
      end
      #2;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, req_ready, exp_ready());
      end
      checks++;
      if (hazard !== exp_hazard()) begin
        errors++; $display("FAIL rand_hazard c%0d got %b exp %b", c, hazard, exp_hazard());
      end
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        errors++; $display("FAIL rand_write c%0d got %b/%0d/%h exp %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      tick();
    end
    rst_i = 1'b0; req_valid = '0; sb_set = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    sb_set = 1'b0; sb_set_addr = '0; flush = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_scoreboard();
    test_x0();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
